// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver with double-buffered, frame-aligned updates
//   clk, reset (async, active-high)
//   digits/digit_en/blink/dp_in: per-digit value, enable, blink and decimal point, captured on load
//   seg/dp/an: registered active-low cathodes and anodes; pending: update waiting; frame_done: wrap pulse
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    frame_done
);
   localparam int DW = $clog2(REFRESH_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [DW-1:0]              div_cnt;
   logic [IW-1:0]              idx;
   logic [BW-1:0]              blink_cnt;
   logic                       blink_phase, tick, wrap, vis;
   logic [NUM_DIGITS-1:0][3:0] pend_val, act_val;
   logic [NUM_DIGITS-1:0]      pend_en, pend_blink, pend_dp, act_en, act_blink, act_dp;
   logic [6:0]                 seg_nxt;
   assign tick = div_cnt == DW'(REFRESH_DIV - 1);
   assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
   assign vis  = act_en[idx] && !(act_blink[idx] && blink_phase);
   always_comb begin
      case (act_val[idx])
         4'h0: seg_nxt = 7'b1000000;
         4'h1: seg_nxt = 7'b1111001;
         4'h2: seg_nxt = 7'b0100100;
         4'h3: seg_nxt = 7'b0110000;
         4'h4: seg_nxt = 7'b0011001;
         4'h5: seg_nxt = 7'b0010010;
         4'h6: seg_nxt = 7'b0000010;
         4'h7: seg_nxt = 7'b1111000;
         4'h8: seg_nxt = 7'b0000000;
         4'h9: seg_nxt = 7'b0010000;
         4'hA: seg_nxt = 7'b0001000;
         4'hB: seg_nxt = 7'b0000011;
         4'hC: seg_nxt = 7'b1000110;
         4'hD: seg_nxt = 7'b0100001;
         4'hE: seg_nxt = 7'b0000110;
         default: seg_nxt = 7'b0001110;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt     <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         pending     <= 1'b0;
         pend_val    <= '0;
         pend_en     <= '0;
         pend_blink  <= '0;
         pend_dp     <= '0;
         act_val     <= '0;
         act_en      <= '0;
         act_blink   <= '0;
         act_dp      <= '0;
         seg         <= '1;
         dp          <= 1'b1;
         an          <= '1;
         frame_done  <= 1'b0;
      end else begin
         div_cnt    <= tick ? '0 : div_cnt + 1'b1;
         frame_done <= wrap;
         if (tick)
            idx <= wrap ? '0 : idx + 1'b1;
         if (wrap) begin
            blink_cnt <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_FRAMES - 1))
               blink_phase <= ~blink_phase;
         end
         if (load) begin
            pend_val   <= digits;
            pend_en    <= digit_en;
            pend_blink <= blink;
            pend_dp    <= dp_in;
         end
         // a load landing on the wrap bypasses the pending buffer so it shows this frame
         if (load && wrap) begin
            act_val   <= digits;
            act_en    <= digit_en;
            act_blink <= blink;
            act_dp    <= dp_in;
            pending   <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end else if (wrap && pending) begin
            act_val   <= pend_val;
            act_en    <= pend_en;
            act_blink <= pend_blink;
            act_dp    <= pend_dp;
            pending   <= 1'b0;
         end
         seg <= vis ? seg_nxt : '1;
         dp  <= vis ? ~act_dp[idx] : 1'b1;
         an  <= vis ? ~(NUM_DIGITS'(1) << idx) : '1;
      end
   end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver: holds a hex value per digit and scans the digits one at a time at a parametrised refresh rate. Each digit can be independently enabled, blinked or given a decimal point. It is the parametrised successor to the single-digit, static-anode octave display. It sits between the piano control logic (octave/note/volume values) and the board's shared `seg`/`an` pins. Updates are double-buffered and applied only at frame boundaries, so the display never tears mid-scan.

## Interface

- `NUM_DIGITS`, default 4: digits scanned, from 1 to 8.
- `REFRESH_DIV`, default 100000: clock cycles each digit is driven, at least 2. At 100 MHz this gives 1 ms per digit.
- `BLINK_FRAMES`, default 250: full frames per blink half-period, at least 1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `digits`  in  4*NUM_DIGITS  hex value per digit. Digit i is `digits[4i+3:4i]`, and digit 0 is the rightmost.
- `digit_en`  in  NUM_DIGITS  1 = digit lit, 0 = blanked.
- `blink`  in  NUM_DIGITS  1 = digit blinks.
- `dp_in`  in  NUM_DIGITS  1 = decimal point lit.
- `load`  in  1  single-cycle strobe that captures `digits`, `digit_en`, `blink` and `dp_in` into the pending buffer.
- `seg`  out  7  segment cathodes, active-low. `seg[0]`=A … `seg[6]`=G.
- `dp`  out  1  decimal-point cathode, active-low.
- `an`  out  NUM_DIGITS  digit anodes, active-low, at most one low at a time.
- `pending`  out  1  high while a loaded update is waiting for the frame boundary.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation

**Divider**
- `div_cnt` counts 0..REFRESH_DIV-1 and then wraps.
- `tick` is asserted when `div_cnt` = REFRESH_DIV-1.

**Scan index**
- `idx` holds values 0..NUM_DIGITS-1.
- On `tick`, `idx` increments. It wraps from NUM_DIGITS-1 to 0.
- The tick that wraps `idx` is the frame wrap. On that cycle `frame_done` is pulsed.

**Buffers**
- Active buffer:
  - Reset value is all zero, so every digit is disabled.
  - The active buffer alone drives the outputs.
- Pending buffer:
  - On `load`, the inputs are captured and `pending` is set to 1.
  - A second `load` before the frame wrap overwrites the pending contents.
- Transfer:
  - On the frame wrap, if `pending` = 1, active ← pending and `pending` ← 0.
  - If `load` and the frame wrap happen in the same cycle, the input values go directly to active and `pending` ends at 0.

**Blink**
- `blink_cnt` counts frame wraps 0..BLINK_FRAMES-1.
- At the wrap of `blink_cnt`, `blink_phase` toggles. Reset value of `blink_phase` is 0.
- A digit is visible when `en[idx]` = 1 and not (`blink[idx]` = 1 and `blink_phase` = 1).

**Decode**
- Standard hex, active-low, written as `seg[6:0]`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- A digit that is not visible drives `seg`=1111111 and `dp`=1, and its anode stays high. All other anodes are high.
- For a visible digit, `dp` = ~`dp[idx]`.

## Timing

- Reset values:
  - `div_cnt`=0, `idx`=0, `blink_cnt`=0, `blink_phase`=0, `pending`=0.
  - Outputs: `seg`=all ones, `dp`=1, `an`=all ones, `frame_done`=0.
- `seg`, `dp`, `an` and `frame_done` are registered. They reflect `idx` and the active buffer of the previous cycle, so output latency is 1 cycle.
- Each digit is driven for exactly REFRESH_DIV cycles. A frame is NUM_DIGITS×REFRESH_DIV cycles.
- An update becomes visible 1 cycle after the first frame wrap at or after its `load`.
- `frame_done` goes high 1 cycle after the wrap tick and stays high for 1 cycle.
- Reset asserted mid-frame returns all state to the reset values immediately. `load` is ignored while reset is asserted.
- When NUM_DIGITS=1:
  - `idx` stays at 0 and every tick is a frame wrap.
  - `an[0]` follows visibility only.

## Test plan

All scenarios use NUM_DIGITS=4, REFRESH_DIV=4 and BLINK_FRAMES=2.

- **Reset:** assert reset, release it, no `load` -> `an`=1111 and `seg`=1111111 for two full frames (32 cycles). `frame_done` pulses every 16 cycles.
- **Load and scan:** `load` with `digits`=16'h4321, `digit_en`=1111 -> `pending`=1 until the wrap. After the wrap:
  - `an` cycles 1110, 1101, 1011, 0111, 4 cycles each.
  - `seg` is 1111001, 0100100, 0110000, 0011001 respectively.
- **Update coalescing:** two `load` strobes in the same frame (values 16'h1111 then 16'h2222) -> only 2222 is ever displayed. 1111 never appears on `seg`.
- **Load on the wrap cycle:** `load` coincident with a frame wrap -> new values are shown from that frame, and `pending` stays 0.
- **Blink and dp:** set `blink`=0001, `dp_in`=0010 and all digits enabled ->
  - Digit 0 is dark during frames 2-3 of every 4-frame period.
  - `dp`=0 only while `an`=1101.
- **Async reset mid-digit:** assert reset while `an`=1011 -> `an`=1111 with no clock edge. Afterwards the display stays blank until a new `load`.
